box_collector: RTL and testbench

Upstream stage for the random box generator in the joystick/VGA game. Compares the player cell position with the current box position. On a hit it scores the collection and issues a one-cycle `create_new_box` request. It also issues a request if the box goes uncollected too long, and rerolls any spawn that lands on the player. Score and miss count drive the seven-segment/HUD logic.

---
 rtl/game_pkg.sv | 20 ++
 rtl/bcd_counter4.sv | 39 +++
 rtl/box_collector.sv | 145 ++++++++++++++
 tb/tb_box_collector.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and enums for the box game: screen geometry, collector FSM states and respawn reasons.
package game_pkg;

    localparam int GRID     = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        ARMED,
        SPAWN,
        SETTLE
    } state_t;

    typedef enum logic [1:0] {
        SCORE,
        MISS,
        REROLL
    } reason_t;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter: synchronous increment with ripple digit carry, holds at 9999.
// The new value is visible the cycle after inc is sampled.
module bcd_counter4 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] value
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic        carry;

    always_comb begin
        value_d = value_q;
        carry   = inc && (value_q != 16'h9999);
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    value_d[4*i +: 4] = 4'd0;
                end else begin
                    value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/box_collector.sv
// Detects player/box overlap, scores hits, forces respawn on timeout, rerolls spawns onto the player.
// create_new_box/collected are registered: a hit sampled in ARMED at edge N pulses them for cycle N+1.
module box_collector #(
    parameter int GRID           = game_pkg::GRID,
    parameter int TIMEOUT_FRAMES = 600,
    parameter int SETTLE_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        frame_tick,
    input  logic [9:0]  player_x,
    input  logic [8:0]  player_y,
    input  logic [9:0]  x_box,
    input  logic [8:0]  y_box,
    output logic        create_new_box,
    output logic        collected,
    output logic [15:0] score_bcd,
    output logic [7:0]  miss_count
);

    import game_pkg::*;

    localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_FRAMES - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [10:0]   GRID_W      = 11'(GRID);

    // Widened to 11 bits so edge + GRID cannot wrap near the screen border.
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] bx;
    logic [10:0] by;
    logic        hit;

    assign px  = {1'b0, player_x};
    assign py  = {2'b00, player_y};
    assign bx  = {1'b0, x_box};
    assign by  = {2'b00, y_box};
    assign hit = (px + GRID_W > bx) && (bx + GRID_W > px) &&
                 (py + GRID_W > by) && (by + GRID_W > py);

    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [SW-1:0] settle_q;
    logic [SW-1:0] settle_d;
    logic          spawn_d;
    reason_t       reason_d;
    logic          create_q;
    logic          collected_q;
    logic [7:0]    miss_q;
    logic [7:0]    miss_d;
    logic          score_inc;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        spawn_d  = 1'b0;
        reason_d = SCORE;
        case (state_q)
            ARMED: begin
                // Hit takes priority over a timeout on the same cycle.
                if (enable && hit) begin
                    state_d  = SPAWN;
                    spawn_d  = 1'b1;
                    reason_d = SCORE;
                end else if (enable && frame_tick) begin
                    if (timer_q == TIMER_LAST) begin
                        state_d  = SPAWN;
                        spawn_d  = 1'b1;
                        reason_d = MISS;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            SPAWN: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LOAD;
            end
            SETTLE: begin
                if (settle_q == '0) begin
                    if (hit) begin
                        state_d  = SPAWN;
                        spawn_d  = 1'b1;
                        reason_d = REROLL;
                    end else begin
                        state_d = ARMED;
                        timer_d = '0;
                    end
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            default: begin
                state_d = ARMED;
                timer_d = '0;
            end
        endcase
    end

    assign score_inc = spawn_d && (reason_d == SCORE);

    always_comb begin
        miss_d = miss_q;
        if (spawn_d && (reason_d == MISS) && (miss_q != 8'hFF)) begin
            miss_d = miss_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SETTLE;
            settle_q    <= SETTLE_LOAD;
            timer_q     <= '0;
            create_q    <= 1'b0;
            collected_q <= 1'b0;
            miss_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            timer_q     <= timer_d;
            create_q    <= spawn_d;
            collected_q <= score_inc;
            miss_q      <= miss_d;
        end
    end

    bcd_counter4 u_score (
        .clk   (clk),
        .rst   (rst),
        .inc   (score_inc),
        .value (score_bcd)
    );

    assign create_new_box = create_q;
    assign collected      = collected_q;
    assign miss_count     = miss_q;

endmodule

// File: tb/tb_box_collector.sv
// Directed plus randomized bench for box_collector against an integer score/miss model.
module tb_box_collector;

    import game_pkg::*;

    localparam int G  = 10;
    localparam int TO = 4;
    localparam int SC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_tick;
    logic [9:0]  player_x;
    logic [8:0]  player_y;
    logic [9:0]  x_box;
    logic [8:0]  y_box;
    logic        create_new_box;
    logic        collected;
    logic [15:0] score_bcd;
    logic [7:0]  miss_count;

    int total = 0;
    int bad   = 0;
    int m_score = 0;
    int m_miss  = 0;

    box_collector #(
        .GRID           (G),
        .TIMEOUT_FRAMES (TO),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .frame_tick     (frame_tick),
        .player_x       (player_x),
        .player_y       (player_y),
        .x_box          (x_box),
        .y_box          (y_box),
        .create_new_box (create_new_box),
        .collected      (collected),
        .score_bcd      (score_bcd),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic box_far();
        x_box = 10'd0;
        y_box = 9'd0;
    endtask

    task automatic box_on_player();
        x_box = player_x;
        y_box = player_y;
    endtask

    task automatic wait_armed(input string tag);
        int n;
        n = 0;
        while (dut.state_q != ARMED && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(dut.state_q == ARMED), 32'd1);
    endtask

    // One scoring hit in four cycles: overlap in ARMED, clear it before the settle check.
    task automatic hit_fast();
        box_on_player();
        step();
        chk("bulk_create", 32'(create_new_box), 32'd1);
        m_score++;
        box_far();
        step();
        step();
        step();
    endtask

    task automatic tick_once(input string tag, input bit expect_req);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk(tag, 32'(create_new_box), 32'(expect_req));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int px;
        int py;
        int dx;
        int dy;
        bit hit_m;

        rst        = 1'b1;
        enable     = 1'b0;
        frame_tick = 1'b0;
        player_x   = 10'd300;
        player_y   = 9'd300;
        box_far();
        #12;
        chk("rst_create", 32'(create_new_box), 32'd0);
        chk("rst_collected", 32'(collected), 32'd0);
        chk("rst_score", 32'(score_bcd), 32'h0000);
        chk("rst_miss", 32'(miss_count), 32'd0);
        chk("rst_state_settle", 32'(dut.state_q == SETTLE), 32'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < SC; i++) begin
            step();
            chk("post_rst_no_req", 32'(create_new_box), 32'd0);
        end
        chk("post_rst_armed", 32'(dut.state_q == ARMED), 32'd1);
        enable = 1'b1;

        // Exact overlap scores
        x_box = 10'd300;
        y_box = 9'd300;
        step();
        m_score++;
        chk("hit_create", 32'(create_new_box), 32'd1);
        chk("hit_collected", 32'(collected), 32'd1);
        chk("hit_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        box_far();
        step();
        chk("hit_create_one_cycle", 32'(create_new_box), 32'd0);
        chk("hit_collected_one_cycle", 32'(collected), 32'd0);
        step();
        step();
        chk("hit_armed_3_later", 32'(dut.state_q == ARMED), 32'd1);

        // Partial overlap
        player_x = 10'd305;
        player_y = 9'd295;
        x_box    = 10'd300;
        y_box    = 9'd300;
        step();
        m_score++;
        chk("partial_create", 32'(create_new_box), 32'd1);
        chk("partial_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        box_far();
        wait_armed("partial_armed");

        // Edge-adjacent cells do not overlap
        player_x = 10'd310;
        player_y = 9'd300;
        x_box    = 10'd300;
        y_box    = 9'd300;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (create_new_box) n++;
        end
        chk("gap_no_req", 32'(n), 32'd0);

        // Timeout after TO frame ticks
        box_far();
        for (int k = 1; k <= TO; k++) begin
            tick_once("timeout_req", k == TO);
            if (k < TO) step();
        end
        m_miss++;
        chk("timeout_collected", 32'(collected), 32'd0);
        chk("timeout_miss", 32'(miss_count), 32'(m_miss));
        chk("timeout_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        wait_armed("timeout_armed");

        // Reroll: box stays on the player through the settle
        player_x = 10'd300;
        player_y = 9'd300;
        box_on_player();
        step();
        m_score++;
        chk("reroll_first", 32'(create_new_box), 32'd1);
        step();
        chk("reroll_gap1", 32'(create_new_box), 32'd0);
        step();
        chk("reroll_gap2", 32'(create_new_box), 32'd0);
        step();
        chk("reroll_second", 32'(create_new_box), 32'd1);
        chk("reroll_not_collected", 32'(collected), 32'd0);
        chk("reroll_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        box_far();
        wait_armed("reroll_armed");

        // Hit and timeout tick on the same cycle
        for (int k = 1; k < TO; k++) begin
            tick_once("simul_pre", 1'b0);
            step();
        end
        box_on_player();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        m_score++;
        chk("simul_create", 32'(create_new_box), 32'd1);
        chk("simul_collected", 32'(collected), 32'd1);
        chk("simul_miss", 32'(miss_count), 32'(m_miss));
        chk("simul_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        box_far();
        wait_armed("simul_armed");

        // Disabled: overlap and ticks ignored, timer frozen
        enable = 1'b0;
        box_on_player();
        for (int k = 0; k < 6; k++) begin
            tick_once("dis_no_req", 1'b0);
            step();
        end
        chk("dis_score", 32'(score_bcd), 32'(to_bcd(m_score)));
        box_far();
        step();
        enable = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            tick_once("dis_timer_frozen", k == TO);
            if (k < TO) step();
        end
        m_miss++;
        chk("dis_miss", 32'(miss_count), 32'(m_miss));
        wait_armed("dis_armed");

        // Random placements near the player
        for (int t = 0; t < 40; t++) begin
            px = int'($urandom_range(500, 100));
            py = int'($urandom_range(400, 100));
            dx = int'($urandom_range(24, 0)) - 12;
            dy = int'($urandom_range(24, 0)) - 12;
            hit_m = (dx < G) && (dx > -G) && (dy < G) && (dy > -G);
            player_x = 10'(px);
            player_y = 9'(py);
            x_box    = 10'(px + dx);
            y_box    = 9'(py + dy);
            step();
            if (hit_m) m_score++;
            chk("rand_create", 32'(create_new_box), 32'(hit_m));
            chk("rand_collected", 32'(collected), 32'(hit_m));
            chk("rand_score", 32'(score_bcd), 32'(to_bcd(m_score)));
            if (hit_m) begin
                box_far();
                wait_armed("rand_armed");
            end
        end

        // Asynchronous reset during SETTLE
        player_x = 10'd300;
        player_y = 9'd300;
        box_on_player();
        step();
        chk("rstmid_create", 32'(create_new_box), 32'd1);
        box_far();
        step();
        #2;
        rst = 1'b1;
        #1;
        m_score = 0;
        m_miss  = 0;
        chk("rstmid_score", 32'(score_bcd), 32'h0000);
        chk("rstmid_miss", 32'(miss_count), 32'd0);
        chk("rstmid_create0", 32'(create_new_box), 32'd0);
        chk("rstmid_state", 32'(dut.state_q == SETTLE), 32'd1);
        step();
        rst = 1'b0;
        for (int i = 0; i < SC; i++) begin
            step();
            chk("rstmid_no_req", 32'(create_new_box), 32'd0);
        end
        chk("rstmid_armed", 32'(dut.state_q == ARMED), 32'd1);

        // Digit carry and saturation
        while (m_score < 99) hit_fast();
        chk("bcd_0099", 32'(score_bcd), 32'h0099);
        hit_fast();
        chk("bcd_0100", 32'(score_bcd), 32'h0100);
        while (m_score < 9999) hit_fast();
        chk("bcd_9999", 32'(score_bcd), 32'h9999);
        hit_fast();
        chk("bcd_saturate", 32'(score_bcd), 32'(to_bcd(m_score)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
